// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: architectural register numbers and
// the opcode / REGIMM-rt encodings control uses to raise link_en.
package mips_pkg;

   localparam int REG_ZERO = 0;
   localparam int REG_V0   = 2;
   localparam int REG_RA   = 31;

   typedef enum logic [5:0] {
      OP_RTYPE  = 6'h00,
      OP_REGIMM = 6'h01,
      OP_J      = 6'h02,
      OP_JAL    = 6'h03,
      OP_BEQ    = 6'h04,
      OP_BNE    = 6'h05,
      OP_ADDI   = 6'h08,
      OP_ADDIU  = 6'h09,
      OP_LB     = 6'h20,
      OP_LH     = 6'h21,
      OP_LW     = 6'h23,
      OP_LBU    = 6'h24,
      OP_LHU    = 6'h25,
      OP_SB     = 6'h28,
      OP_SH     = 6'h29,
      OP_SW     = 6'h2b
   } opcode_e;

   typedef enum logic [4:0] {
      RT_BLTZ   = 5'h00,
      RT_BGEZ   = 5'h01,
      RT_BLTZAL = 5'h10,
      RT_BGEZAL = 5'h11
   } regimm_rt_e;

endpackage

// File: rtl/regfile_byte_merge.sv
// Byte-lane merge: enabled lanes come from new_word, the rest from
// old_word. Shared by the register write path and the read bypass.
module regfile_byte_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   new_word,
   input  logic [DATA_W/8-1:0] byteen,
   output logic [DATA_W-1:0]   merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < DATA_W/8; i++) begin
         if (byteen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port register file with byte-merged writes, link path and a
// pending-load scoreboard. Define REGFILE_BYPASS_EN for write->read bypass.
module mips_regfile_mp
   import mips_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  NUM_REGS = 32,
   parameter int  NUM_RD   = 2,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W/8-1:0]      wr_byteen,
   input  logic                     link_en,
   input  logic                     resv_en,
   input  logic [AW-1:0]            resv_addr,
   output logic [DATA_W-1:0]        reg_v0
);

   localparam logic [AW-1:0] LINK_A = AW'(NUM_REGS - 1);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic [AW-1:0]       eff_addr;
   logic [DATA_W/8-1:0] eff_be;
   logic [DATA_W-1:0]   wr_merged;
   logic                wr_hit;

   assign eff_addr = link_en ? LINK_A : wr_addr;
   assign eff_be   = link_en ? '1 : wr_byteen;
   assign wr_hit   = wr_en && (|eff_be);

   regfile_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .old_word (regs[eff_addr]),
      .new_word (wr_data),
      .byteen   (eff_be),
      .merged   (wr_merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
         pend <= '0;
      end else begin
         if (wr_hit && eff_addr != '0) regs[eff_addr] <= wr_merged;
         if (wr_hit) pend[eff_addr] <= 1'b0;
         // later assignment wins: a new load issue beats its own clear
         if (resv_en && resv_addr != '0) pend[resv_addr] <= 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[p*AW +: AW];

      always_comb begin
         rd_data[p*DATA_W +: DATA_W] = (a == '0) ? '0 : regs[a];
         rd_busy[p] = pend[a];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && a != '0 && a == eff_addr) begin
            rd_data[p*DATA_W +: DATA_W] = wr_merged;
            if (wr_hit && !(resv_en && resv_addr == a)) rd_busy[p] = 1'b0;
         end
`endif
      end
   end

   if (NUM_REGS > REG_V0) begin : g_v0
      assign reg_v0 = regs[AW'(REG_V0)];
   end else begin : g_no_v0
      assign reg_v0 = '0;
   end

endmodule
